mips_control_fsm: RTL
=====================

MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 SHALL have parameter JUMP_EN, default 1, meaning: 1 = decode j (op 000010); 0 = treat j as unsupported opcode.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 SHALL have port Op  input  6  instruction opcode from instruction register.
REQ-005 SHALL have port Funct  input  6  R-type function field.
REQ-006 SHALL have port Zero  input  1  ALU zero flag.
REQ-007 SHALL have port ALUControl  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt-compare.
REQ-008 SHALL have ports IorD, ALUSrcA, RegDst, MemtoReg, RegWrite, MemWrite, IRWrite, PCWrite, Branch, each an output of width 1 that is the standard multicycle datapath control.
REQ-009 SHALL have ports ALUSrcB  output  2  (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2) and PCSrc  output  2  (00 ALUResult, 01 ALUOut, 10 jump target).
REQ-010 SHALL have port PCEn  output  1  PC register enable.

Function
REQ-011 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP; one transition per clk.
REQ-012 SHALL transition: FETCH->DECODE; MEMREAD->MEMWB; MEMADR->MEMREAD for lw, ->MEMWRITE for sw; EXECUTE->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
REQ-013 SHALL transition from DECODE on Op: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP (JUMP_EN=1 only), any other->FETCH (no state written).
REQ-014 SHALL drive, per state, with all signals not listed = 0 (ALUOp is an internal 2-bit signal):
 - FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUOp=00.
 - DECODE: ALUSrcB=11, ALUOp=00.
 - MEMADR, ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
 - MEMREAD: IorD=1.
 - MEMWRITE: IorD=1, MemWrite=1.
 - MEMWB: MemtoReg=1, RegWrite=1.
 - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
 - ALUWB: RegDst=1, RegWrite=1.
 - ADDIWB: RegWrite=1.
 - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
 - JUMP: PCSrc=10, PCWrite=1.
REQ-015 SHALL decode ALUControl combinationally: ALUOp 00->010, 01->110, 10->by Funct (100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010), 11->010.
REQ-016 SHALL, for R-type with unsupported Funct, go EXECUTE->FETCH, skipping ALUWB (RegWrite never asserted).
REQ-017 SHALL compute PCEn = PCWrite | (Branch & Zero) combinationally; Zero is ignored outside BRANCH.
REQ-018 SHALL sample Op/Funct only for next-state and ALUControl decisions; no input registering, so state-change latency is exactly 1 clk.
REQ-019 SHALL produce the instruction cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported op 2.

Reset
REQ-020 SHALL, when reset=1 at a rising edge, enter FETCH regardless of current state; reset has priority over all transitions.
REQ-021 SHALL drive FETCH outputs (IRWrite=1, PCWrite=1, PCEn=1, ALUControl=010, all others 0) while in the reset state.
REQ-022 SHALL abandon any in-flight instruction on reset mid-operation; no RegWrite/MemWrite pulse after reset deasserts until the instruction's writeback state is reached again.

Verification
REQ-023 Reset held 2 clks from MEMREAD -> state FETCH, IRWrite=1, PCEn=1, MemWrite=0, RegWrite=0.
REQ-024 Op=100011 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 and MemtoReg=1 only in cycle 5; ALUControl=010 in MEMADR.
REQ-025 Op=000100, Zero=1 in BRANCH -> PCEn=1, PCSrc=01, ALUControl=110; repeat with Zero=0 -> PCEn=0.
REQ-026 Op=000000, Funct=100100 -> ALUControl=000 in EXECUTE, RegDst=1 in ALUWB; Funct=111111 -> EXECUTE->FETCH, RegWrite never 1.
REQ-027 Op=000010 with JUMP_EN=1 -> JUMP, PCSrc=10, PCEn=1; JUMP_EN=0 or Op=111111 -> DECODE->FETCH, no writes.

Source files
------------

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main controller: Moore state machine sequencing fetch, decode,
// memory, ALU, branch and jump steps, plus the ALU-control decoder.
module mips_control_fsm #(
    parameter int JUMP_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic [2:0] ALUControl,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam bit JUMP_SUPPORTED = (JUMP_EN != 0);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] w_alu_op;
    logic [2:0] w_funct_ctrl;
    logic       w_funct_ok;

    // NOTE: state flops use non-blocking assignment; reset here is synchronous,
    // so it only takes effect on a rising clk edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // R-type function decode; unknown functions are flagged so EXECUTE can
    // drop the instruction without a register write.
    always_comb begin
        w_funct_ctrl = ALU_ADD;
        w_funct_ok   = 1'b1;
        case (Funct)
            FN_ADD:  w_funct_ctrl = ALU_ADD;
            FN_SUB:  w_funct_ctrl = ALU_SUB;
            FN_AND:  w_funct_ctrl = ALU_AND;
            FN_OR:   w_funct_ctrl = ALU_OR;
            FN_SLT:  w_funct_ctrl = ALU_SLT;
            default: w_funct_ok   = 1'b0;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: w_next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = JUMP_SUPPORTED ? S_JUMP : S_FETCH;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_EXECUTE:  w_next_state = w_funct_ok ? S_ALUWB : S_FETCH;
            S_ADDIEX:   w_next_state = S_ADDIWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP:
                        w_next_state = S_FETCH;
            default:    w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        IorD     = 1'b0;
        ALUSrcA  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        w_alu_op = 2'b00;
        case (r_state)
            S_FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD: begin
                IorD = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA  = 1'b1;
                w_alu_op = 2'b10;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                w_alu_op = 2'b01;
                PCSrc    = 2'b01;
                Branch   = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: begin
                IRWrite = 1'b0;
            end
        endcase
    end

    always_comb begin
        case (w_alu_op)
            2'b00:   ALUControl = ALU_ADD;
            2'b01:   ALUControl = ALU_SUB;
            2'b10:   ALUControl = w_funct_ctrl;
            default: ALUControl = ALU_ADD;
        endcase
    end

    // Branch is only high in BRANCH, so Zero has no effect elsewhere.
    assign PCEn = PCWrite | (Branch & Zero);

endmodule
